// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned PC_STEP_DEFAULT = 4;

    function automatic addr_t next_pc(input addr_t pc, input int unsigned step);
        return pc + addr_t'(step);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous clear, used for the instruction
// buffer and the in-order request PC queue.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads as zero while empty so downstream data is clean without a valid.
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: PC sequencing, credit-limited memory requests and
// a redirect flush. Define FETCH_PERF_EN to add the perf counter outputs.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t       RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_STEP   = PC_STEP_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`endif
);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    state_t        state;
    state_t        state_next;
    addr_t         fetch_pc;
    addr_t         pcq_head;
    logic [CW-1:0] stale;
    logic [CW-1:0] stale_next;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] pcq_count;
    logic [63:0]   buf_head;
    logic          buf_full, buf_empty, pcq_full, pcq_empty;
    logic          in_run, in_flush, redirect, credit, req_fire;
    logic          run_rsp, flush_rsp, buf_push, buf_pop, pcq_push;
    logic          unused_flags;

    assign in_run   = (state == RUN);
    assign in_flush = (state == FLUSH);
    assign redirect = redirect_valid & (in_run | in_flush);
    // In RUN the PC queue depth equals the number of live outstanding requests.
    assign credit   = ({1'b0, buf_count} + {1'b0, pcq_count}) < SW'(BUF_DEPTH);

    assign imem_req_valid = in_run & credit;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign run_rsp   = in_run & imem_rsp_valid & ~pcq_empty;
    assign flush_rsp = in_flush & imem_rsp_valid & (stale != '0);
    assign buf_push  = run_rsp & ~redirect;
    assign buf_pop   = inst_valid & inst_ready & ~redirect;
    assign pcq_push  = req_fire & ~redirect;

    assign inst_valid   = ~buf_empty;
    assign inst_pc      = buf_head[63:32];
    assign inst_data    = buf_head[31:0];
    assign unused_flags = buf_full | pcq_full;

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(64)) u_inst_buf (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (buf_push),
        .pop   (buf_pop),
        .wdata ({pcq_head, imem_rsp_data}),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (pcq_push),
        .pop   (buf_push),
        .wdata (fetch_pc),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    always_comb begin
        state_next = state;
        stale_next = stale;
        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                // A request granted in the redirect cycle is already stale; a response in it is dropped.
                if (redirect) begin
                    stale_next = pcq_count + CW'(req_fire) - CW'(run_rsp);
                    state_next = (stale_next != '0) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                stale_next = stale - CW'(flush_rsp);
                if (stale_next == '0) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            stale    <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            stale <= stale_next;
            if (redirect)      fetch_pc <= redirect_pc;
            else if (req_fire) fetch_pc <= next_pc(fetch_pc, PC_STEP);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (buf_pop && perf_fetched != '1)    perf_fetched   <= perf_fetched + 32'd1;
            if (redirect && perf_redirects != '1) perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: expected instructions are queued as requests are
// granted and compared as the unit hands them out; memory answers in order.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        d2_req_valid;
    logic [31:0] d2_req_addr;
    logic        d2_inst_valid;
    logic [31:0] d2_inst_data;
    logic [31:0] d2_inst_pc;
    logic        d2_req_ready = 1'b1;
    logic        d2_rsp_valid = 1'b0;
    logic [31:0] d2_rsp_data = '0;
    logic        d2_inst_ready = 1'b0;
    logic        d2_redirect_valid = 1'b0;
    logic [31:0] d2_redirect_pc = '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_redirects, d2_perf_fetched, d2_perf_redirects;
`endif

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] d2_q[$];
    int          checks = 0;
    int          failures = 0;
    int          req_cnt = 0;
    int          inst_cnt = 0;
    logic [31:0] exp_addr = '0;
    bit          mem_stall = 0;
    bit          got_req = 0;
    bit          got_inst = 0;
    logic [31:0] first_req_addr = '0;
    logic [31:0] first_inst_pc = '0;

    initial forever #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (d2_redirect_valid),
        .redirect_pc    (d2_redirect_pc),
        .imem_req_valid (d2_req_valid),
        .imem_req_ready (d2_req_ready),
        .imem_req_addr  (d2_req_addr),
        .imem_rsp_valid (d2_rsp_valid),
        .imem_rsp_data  (d2_rsp_data),
        .inst_valid     (d2_inst_valid),
        .inst_ready     (d2_inst_ready),
        .inst_data      (d2_inst_data),
        .inst_pc        (d2_inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (d2_perf_fetched),
        .perf_redirects (d2_perf_redirects)
`endif
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0F0F;
    endfunction

    // One clock: observe handshakes at negedge, then drive the memory response after the edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            checks++;
            if (imem_req_addr !== exp_addr) begin
                failures++;
                $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_addr);
            end
            if (!got_req) begin
                got_req = 1;
                first_req_addr = imem_req_addr;
            end
            req_cnt++;
            mem_q.push_back(imem_req_addr);
            if (!redirect_valid) exp_q.push_back('{pc: imem_req_addr, data: mem_data(imem_req_addr)});
            exp_addr = exp_addr + 32'd4;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            checks++;
            if (!got_inst) begin
                got_inst = 1;
                first_inst_pc = inst_pc;
            end
            inst_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL inst_unexpected: got pc %h expected no instruction", inst_pc);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst_data !== e.data) begin
                    failures++;
                    $display("FAIL inst: got pc %h data %h expected pc %h data %h",
                             inst_pc, inst_data, e.pc, e.data);
                end
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_addr = redirect_pc;
        end
        if (d2_req_valid) d2_q.push_back(d2_req_addr);
        @(posedge clk);
        #1;
        if (!mem_stall && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_q.delete();
        exp_q.delete();
        d2_q.delete();
        exp_addr  = 32'h0;
        mem_stall = 0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        got_req  = 0;
        got_inst = 0;
        req_cnt  = 0;
        inst_cnt = 0;
    endtask

    task automatic test_reset();
        logic exp_v;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        apply_reset();
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valids: got %b expected 00", {imem_req_valid, inst_valid});
        end
        checks++;
        if (imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 00000000", imem_req_addr);
        end
        checks++;
        if ({inst_data, inst_pc} !== 64'h0) begin
            failures++;
            $display("FAIL reset_inst: got %h expected 0", {inst_data, inst_pc});
        end
        release_reset();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_no_req: got %b expected 0", imem_req_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            exp_v = (i == 3);
            checks++;
            if (inst_valid !== exp_v) begin
                failures++;
                $display("FAIL first_inst_latency cycle %0d: got %b expected %b", i, inst_valid, exp_v);
            end
        end
        repeat (10) cycle();
        checks++;
        if (first_req_addr !== 32'h0 || inst_cnt < 5) begin
            failures++;
            $display("FAIL seq_fetch: got first %h insts %0d expected 00000000 and >=5", first_req_addr, inst_cnt);
        end
    endtask

    task automatic test_backpressure();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        apply_reset();
        release_reset();
        repeat (12) cycle();
        checks++;
        if (req_cnt != 2 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL credit_limit: got reqs %0d valid %b expected 2 and 0", req_cnt, imem_req_valid);
        end
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL buffer_hold: got %b expected 1", inst_valid);
        end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL credit_return: got %b expected 1", imem_req_valid);
        end
        repeat (4) cycle();
        checks++;
        if (req_cnt != 3) begin
            failures++;
            $display("FAIL credit_refill: got %0d expected 3", req_cnt);
        end
        #2;
        apply_reset();
        checks++;
        if ({inst_valid, inst_data, inst_pc} !== 65'h0) begin
            failures++;
            $display("FAIL async_reset_buffer: got %b %h %h expected 0 0 0", inst_valid, inst_data, inst_pc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        apply_reset();
        release_reset();
        repeat (4) cycle();
        imem_req_ready = 1'b0;
        hold = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (imem_req_addr !== hold) begin
                failures++;
                $display("FAIL stall_addr cycle %0d: got %h expected %h", i, imem_req_addr, hold);
            end
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_valid: got %b expected 1", imem_req_valid);
        end
        imem_req_ready = 1'b1;
        got_req = 0;
        cycle();
        checks++;
        if (!got_req || first_req_addr !== hold) begin
            failures++;
            $display("FAIL stall_no_skip: got %h expected %h", first_req_addr, hold);
        end
        repeat (6) cycle();
    endtask

    task automatic setup_two_outstanding();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        apply_reset();
        mem_stall = 1;
        release_reset();
        repeat (4) cycle();
    endtask

    task automatic finish_flush(input logic [31:0] target, input string name);
        int  n;
        bit  leaked;
        mem_stall = 0;
        got_req   = 0;
        got_inst  = 0;
        n         = 0;
        leaked    = 0;
        while (!imem_req_valid && n < 10) begin
            cycle();
            if (inst_valid) leaked = 1;
            n++;
        end
        checks++;
        if (n >= 10 || leaked || mem_q.size() != 0) begin
            failures++;
            $display("FAIL %s_flush: got cycles %0d leaked %b pending %0d expected <10 0 0",
                     name, n, leaked, mem_q.size());
        end
        n = 0;
        while (!got_inst && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (first_req_addr !== target || first_inst_pc !== target) begin
            failures++;
            $display("FAIL %s_target: got req %h inst %h expected %h", name, first_req_addr, first_inst_pc, target);
        end
        repeat (4) cycle();
    endtask

    task automatic test_redirect();
        setup_two_outstanding();
        checks++;
        if (imem_req_valid !== 1'b0 || mem_q.size() != 2) begin
            failures++;
            $display("FAIL redirect_setup: got valid %b outstanding %0d expected 0 2", imem_req_valid, mem_q.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            failures++;
            $display("FAIL redirect_flush_entry: got %b expected 00", {imem_req_valid, inst_valid});
        end
        finish_flush(32'h100, "redirect");
    endtask

    task automatic test_redirect_flush();
        setup_two_outstanding();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_pc    = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            failures++;
            $display("FAIL flush_redirect_hold: got %b expected 00", {imem_req_valid, inst_valid});
        end
        finish_flush(32'h300, "flush_redirect");
    endtask

    task automatic test_wrap();
        apply_reset();
        release_reset();
        repeat (5) cycle();
        checks++;
        if (d2_q.size() < 2) begin
            failures++;
            $display("FAIL wrap_count: got %0d expected >=2", d2_q.size());
        end else if (d2_q[0] !== 32'hFFFF_FFFC || d2_q[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000", d2_q[0], d2_q[1]);
        end
    endtask

    task automatic test_async_reset();
        setup_two_outstanding();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        #2;
        apply_reset();
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00 || imem_req_addr !== 32'h0 ||
            {inst_data, inst_pc} !== 64'h0) begin
            failures++;
            $display("FAIL flush_async_reset: got valids %b addr %h inst %h %h expected 00 0 0 0",
                     {imem_req_valid, inst_valid}, imem_req_addr, inst_data, inst_pc);
        end
        release_reset();
        repeat (5) cycle();
        checks++;
        if (!got_inst || first_req_addr !== 32'h0 || first_inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_fetch: got req %h inst %h seen %b expected 0 0 1",
                     first_req_addr, first_inst_pc, got_inst);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        release_reset();
        for (int i = 0; i < 60; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            mem_stall      = ($urandom_range(0, 4) == 0);
            redirect_valid = (i == 20 || i == 21 || i == 40 || $urandom_range(0, 15) == 0);
            redirect_pc    = 32'h400 + 32'(i) * 32'h40;
            cycle();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_stall      = 0;
        repeat (12) cycle();
        checks++;
        if (inst_cnt < 10 || exp_q.size() > 2) begin
            failures++;
            $display("FAIL back_to_back: got insts %0d pending %0d expected >=10 and <=2", inst_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_stall();
        test_redirect();
        test_redirect_flush();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, the PC increment per sequential fetch.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, the instruction buffer entries (power of 2, 2..8).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port redirect_valid, input, 1, a branch/jump redirect request.
REQ-007 SHALL have port redirect_pc, input, 32, the redirect target address.
REQ-008 SHALL have ports imem_req_valid, output, 1; imem_req_ready, input, 1; imem_req_addr, output, 32, forming the fetch request handshake.
REQ-009 SHALL have ports imem_rsp_valid, input, 1; imem_rsp_data, input, 32, carrying in-order responses that are never back-pressured.
REQ-010 SHALL have ports inst_valid, output, 1; inst_ready, input, 1; inst_data, output, 32; inst_pc, output, 32, forming the CPU-side instruction handshake.

Function
REQ-011 SHALL complete a request on a cycle with imem_req_valid and imem_req_ready both high, then advance fetch_pc by PC_STEP, wrapping modulo 2^32.
REQ-012 SHALL assert imem_req_valid only in RUN and only when (buffer occupancy + outstanding requests) < BUF_DEPTH.
REQ-013 SHALL keep imem_req_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-014 SHALL push each non-stale response into the buffer together with its request PC, taken from an in-order PC queue.
REQ-015 SHALL drive the buffer head on inst_valid/inst_data/inst_pc, popping it when inst_valid and inst_ready are both high; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-016 SHALL have a response-to-inst_valid latency of 1 cycle when the buffer is empty.
REQ-017 SHALL use an FSM with states BOOT, RUN, and FLUSH.
REQ-018 SHALL move BOOT to RUN one cycle after reset deasserts, issuing no request while in BOOT.
REQ-019 SHALL, on redirect_valid in RUN: clear the buffer, set fetch_pc to redirect_pc, and mark all outstanding requests stale; it SHALL then go to FLUSH if the outstanding count is nonzero, otherwise stay in RUN.
REQ-020 SHALL, in FLUSH, discard responses and decrement the stale count, return to RUN when the count reaches 0, and issue no requests.
REQ-021 SHALL, on redirect_valid in FLUSH: update fetch_pc, remain in FLUSH, and treat every outstanding request as stale.
REQ-022 SHALL give redirect priority over a same-cycle pop, push, or request handshake; the request completing in that cycle SHALL count as stale.
REQ-023 SHALL hold inst_valid low in the cycle after a redirect.

Reset
REQ-024 SHALL, with reset high, immediately force: state=BOOT, fetch_pc=RESET_PC, occupancy=0, outstanding=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
REQ-025 SHALL, on reset mid-operation, abandon all in-flight requests; responses arriving during or after reset for pre-reset requests are a system error and SHALL not be tracked.

Configuration
REQ-026 SHALL, with macro FETCH_PERF_EN defined, add outputs perf_fetched (32 bits, counts inst handshakes) and perf_redirects (32 bits, counts redirects), both reset to 0 and saturating at all-ones.
REQ-027 SHALL, without FETCH_PERF_EN, have neither those ports nor those counters.

Structure
REQ-028 SHALL place the FSM state enum, PC_STEP default, and a 32-bit addr_t typedef in shared package fetch_pkg.
REQ-029 SHALL implement the instruction/PC buffer as one sub-module, fetch_fifo (parameterised depth and width, push/pop/full/empty).

Verification
REQ-030 SHALL cover reset release with imem_req_ready=1 and a memory of 1-cycle latency -> addresses 0x0, 0x4, 0x8… and the first inst_valid 3 cycles after reset falls.
REQ-031 SHALL cover inst_ready held low -> exactly BUF_DEPTH requests issued, then imem_req_valid=0 until a pop.
REQ-032 SHALL cover redirect to 0x100 with 2 requests outstanding -> FLUSH, 2 responses dropped, next request addr 0x100, next inst_pc 0x100.
REQ-033 SHALL cover imem_req_ready low for 5 cycles -> imem_req_addr held constant, no PC skip.
REQ-034 SHALL cover RESET_PC=32'hFFFF_FFFC -> second request addr 0x0.
REQ-035 SHALL cover async reset asserted mid-FLUSH -> all outputs reach reset values before the next clk edge.
